example_substitution_pipe: RTL and testbench
============================================

Name: example_substitution_pipe

Overview:
- Parametrised, pipelined successor to the single-output substitution benchmark.
- Evaluates LANES copies of the redundant cone out = (T&U)|(T&~U), with T = (a&b&~c)|(a&b&~c&d) and U = (e|f)&(e|f|g).
- Wraps the cones in an elastic valid/ready pipeline of STAGES registers and counts output transactions.
- Serves as an ABC benchmark mixing sequential state with optimisable combinational cones.

Parameters:
- LANES, 4, number of independent bit-lanes (1..32).
- STAGES, 2, number of pipeline register stages (1..4).
- CNT_W, 8, width of transaction and mismatch counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline accepts a beat.
- a,b,c,d,e,f,g  in  LANES each  per-lane cone inputs.
- h  in  LANES  per-lane enable; 0 forces lane result to 0.
- flt_inj  in  LANES  per-lane fault injection; XORed into the redundant result.
- clr  in  1  synchronous clear of counters and err.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out  out  LANES  per-lane result.
- tx_cnt  out  CNT_W  completed output handshakes.
- mism_cnt  out  CNT_W  accumulated mismatching lanes (checker only).
- err  out  1  sticky mismatch flag (checker only).

Behaviour:
- Clocking and reset: single clock domain clk; rst is synchronous and active-high.
- Lane function at capture, per lane i:
  - res[i] = ((T&U)|(T&~U))[i] ^ flt_inj[i].
  - The result is then ANDed with h[i].
  - Logic is fully combinational ahead of stage 0.
  - Stages 1..STAGES-1 pass data through unchanged.
- Each stage holds a valid bit vld[k] and a data register.
  - Stage k ready: rdy[k] = ~vld[k] | rdy[k+1].
  - rdy[STAGES] = out_ready.
- in_ready = rdy[0] & ~rst.
  - An input handshake (in_valid & in_ready) loads stage 0.
- out_valid = vld[STAGES-1]; out = data of the last stage.
  - out is held stable while out_valid=1 and out_ready=0.
- Latency: with out_ready held 1, a beat accepted in cycle n appears on out in cycle n+STAGES.
- Throughput: 1 beat/cycle with no bubbles.
- Stall behaviour:
  - Full pipeline with out_ready=0: in_ready=0 and no data is lost.
  - Raising out_ready lets a new input enter in the same cycle (pass-through readiness).
- tx_cnt increments on each out_valid & out_ready and wraps from 2^CNT_W-1 to 0.
- clr clears tx_cnt, mism_cnt and err next cycle.
  - If clr and a handshake occur in the same cycle, clr wins and that beat is not counted.
- Reset values: all vld=0, out=0, out_valid=0, tx_cnt=0, mism_cnt=0, err=0.
  - in_ready=0 while rst=1.
- Reset mid-operation: all in-flight beats are discarded; no handshake is counted in the reset cycle.

Optional Feature:
- Macro: SUBST_CHECK_EN.
- Defined:
  - At capture, compute the reduced form r[i] = a[i]&b[i]&~c[i]&h[i].
  - Register the mismatch vector (res ^ r) alongside the data through all stages.
  - On each output handshake, add its popcount to mism_cnt, saturating at 2^CNT_W-1 (no wrap).
  - err sets when a counted beat has a nonzero mismatch vector and stays set until clr or rst.
- Undefined: mism_cnt and err are tied to 0 and no checker registers are instantiated.

Decomposition:
- Package subst_pkg holds:
  - LANES_MAX=32 and STAGES_MAX=4, with parameter range assertions against them;
  - the popcount function;
  - a saturating-add helper.
- One natural sub-module, subst_pipe_stage:
  - one elastic register stage (vld, data, optional mismatch);
  - instantiated STAGES times via generate.

Test Plan:
1. Reset then single beat (LANES=4, STAGES=2): a=b=e=h=4'hF, c=d=f=g=0, flt_inj=0, out_ready=1 -> out=4'hF two cycles later; tx_cnt=1.
2. Lane enable: same inputs with h=4'b0101 -> out=4'b0101; c=4'hF instead -> out=0.
3. Backpressure: stream 6 beats with out_ready=0 -> in_ready drops after 2 accepted beats; release out_ready -> all 6 beats emerge in order, none lost or duplicated; tx_cnt=6.
4. Counter wrap (CNT_W=3): complete 9 handshakes -> tx_cnt=1.
5. Checker (SUBST_CHECK_EN): flt_inj=4'b0011 on one beat, same inputs as scenario 1 -> mism_cnt=2 and err=1 after its handshake; assert clr in the same cycle as the next handshake -> mism_cnt=0, tx_cnt=0, err=0.
6. Reset mid-stream: assert rst with both stages valid -> next cycle out_valid=0 and counters 0; after release, the first new beat has latency STAGES.

Source files
------------

// File: rtl/subst_pkg.sv
// Shared limits and arithmetic helpers for the substitution pipeline.
// Optional checker is enabled with the SUBST_CHECK_EN macro (see top).
package subst_pkg;

  localparam int LANES_MAX  = 32;
  localparam int STAGES_MAX = 4;
  localparam int CNT_W_MAX  = 32;

  // Number of set bits in a lane vector (0..LANES_MAX needs 6 bits).
  function automatic logic [5:0] popcount(input logic [LANES_MAX-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < LANES_MAX; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  // Unsigned add that clamps at cap instead of wrapping.
  function automatic logic [CNT_W_MAX-1:0] sat_add(input logic [CNT_W_MAX-1:0] acc,
                                                   input logic [CNT_W_MAX-1:0] inc,
                                                   input logic [CNT_W_MAX-1:0] cap);
    logic [CNT_W_MAX:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, cap}) begin
      return cap;
    end
    return sum[CNT_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/subst_pipe_stage.sv
// One elastic register stage: holds a valid bit and a W-bit payload.
// Ready passes through combinationally so a full pipeline keeps streaming.
module subst_pipe_stage #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  input  logic         dn_rdy,
  output logic         vld,
  output logic [W-1:0] data,
  output logic         rdy
);

  // Stage can accept when empty or when the downstream stage drains it.
  assign rdy = ~vld | dn_rdy;

  // Load a new beat (or a bubble) whenever this stage is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (rdy) begin
      vld <= in_vld;
      if (in_vld) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/example_substitution_pipe.sv
// LANES redundant logic cones feeding an elastic STAGES-deep pipeline with a
// transaction counter. Define SUBST_CHECK_EN to carry a per-lane mismatch
// vector against the reduced cone and accumulate it into mism_cnt / err.
module example_substitution_pipe
  import subst_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] c,
  input  logic [LANES-1:0] d,
  input  logic [LANES-1:0] e,
  input  logic [LANES-1:0] f,
  input  logic [LANES-1:0] g,
  input  logic [LANES-1:0] h,
  input  logic [LANES-1:0] flt_inj,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             err
);

  if (LANES < 1 || LANES > LANES_MAX) begin : g_bad_lanes
    $error("LANES out of range");
  end
  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("STAGES out of range");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("CNT_W out of range");
  end

`ifdef SUBST_CHECK_EN
  localparam int W = 2 * LANES;
`else
  localparam int W = LANES;
`endif

  logic [LANES-1:0] t_p0;
  logic [LANES-1:0] u_p0;
  logic [LANES-1:0] red_p0;
  logic [LANES-1:0] res_p0;
  logic [W-1:0]     cap_p0;
  logic             in_fire;
  logic             tx_fire;

  logic [STAGES-1:0] vld_p;
  logic [STAGES:0]   rdy_p;
  logic [W-1:0]      dat_p [STAGES];

  // ---- capture: combinational cones ahead of stage 0 ----
  // The cone is deliberately redundant; it reduces to a&b&~c.
  always_comb begin
    t_p0   = (a & b & ~c) | (a & b & ~c & d);
    u_p0   = (e | f) & (e | f | g);
    red_p0 = (t_p0 & u_p0) | (t_p0 & ~u_p0);
    res_p0 = (red_p0 ^ flt_inj) & h;
`ifdef SUBST_CHECK_EN
    cap_p0 = {res_p0 ^ (a & b & ~c & h), res_p0};
`else
    cap_p0 = res_p0;
`endif
  end

  assign rdy_p[STAGES] = out_ready;
  assign in_ready      = rdy_p[0] & ~rst;
  assign in_fire       = in_valid & in_ready;

  // ---- stages 0..STAGES-1: elastic registers, data passes unchanged ----
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      subst_pipe_stage #(.W(W)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .in_vld (in_fire),
        .in_data(cap_p0),
        .dn_rdy (rdy_p[k+1]),
        .vld    (vld_p[k]),
        .data   (dat_p[k]),
        .rdy    (rdy_p[k])
      );
    end else begin : g_rest
      subst_pipe_stage #(.W(W)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .in_vld (vld_p[k-1]),
        .in_data(dat_p[k-1]),
        .dn_rdy (rdy_p[k+1]),
        .vld    (vld_p[k]),
        .data   (dat_p[k]),
        .rdy    (rdy_p[k])
      );
    end
  end

  // ---- output: last stage drives the handshake and counters ----
  assign out_valid = vld_p[STAGES-1];
  assign out       = dat_p[STAGES-1][LANES-1:0];
  assign tx_fire   = out_valid & out_ready;

  // Completed-handshake counter; clr and rst take priority over a handshake.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tx_cnt <= '0;
    end else if (tx_fire) begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

`ifdef SUBST_CHECK_EN
  localparam logic [CNT_W_MAX-1:0] CNT_MAX = CNT_W_MAX'((64'd1 << CNT_W) - 64'd1);

  logic [LANES-1:0]     mism_last;
  logic [LANES_MAX-1:0] mism_wide;

  assign mism_last = dat_p[STAGES-1][W-1:LANES];

  // Zero-extend the mismatch vector to the popcount helper's width.
  always_comb begin
    mism_wide              = '0;
    mism_wide[LANES-1:0]   = mism_last;
  end

  // Saturating mismatch accumulator and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      mism_cnt <= '0;
      err      <= 1'b0;
    end else if (tx_fire) begin
      mism_cnt <= CNT_W'(sat_add(CNT_W_MAX'(mism_cnt), CNT_W_MAX'(popcount(mism_wide)), CNT_MAX));
      if (|mism_last) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign mism_cnt = '0;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_example_substitution_pipe.sv
// Scoreboard bench: stimulus pushes hand-computed expected lane results,
// a negedge monitor pops and compares on every output handshake.
module tb_example_substitution_pipe;

  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int CNT_W  = 3;
`ifdef SUBST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] a, b, c, d, e, f, g, h, flt_inj;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] mism_cnt;
  logic             err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [LANES-1:0] sb_q[$];
  bit s3_done;

  example_substitution_pipe #(.LANES(LANES), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .flt_inj(flt_inj),
    .clr(clr), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .tx_cnt(tx_cnt), .mism_cnt(mism_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare every output handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'(out), 32'hDEAD);
      end else begin
        check("out_data", 32'(out), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [3:0] av, bv, cv, dv, ev, fv, gv, hv, fl, ex);
    bit ok;
    a = av; b = bv; c = cv; d = dv; e = ev; f = fv; g = gv; h = hv; flt_inj = fl;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", 32'(ok), 32'd1);
    if (ok) sb_q.push_back(ex);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; d = '0; e = '0; f = '0; g = '0; h = '0; flt_inj = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_tx_cnt", 32'(tx_cnt), 32'd0);
    check("rst_mism_cnt", 32'(mism_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Scenario 1: single beat, latency STAGES
    send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF);
    check("s1_lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("s1_lat_valid", 32'(out_valid), 32'd1);
    check("s1_out", 32'(out), 32'hF);
    @(posedge clk); #1;
    check("s1_tx_cnt", 32'(tx_cnt), 32'd1);

    // Scenario 2: lane enable and cone variants
    send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'b0101, 4'h0, 4'b0101);
    send(4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    send(4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF);
    send(4'hC, 4'hA, 4'h2, 4'h0, 4'h1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h8);
    drain();

    // Scenario 3: backpressure, 6 beats
    clr_pulse();
    out_ready = 1'b0;
    s3_done = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'(i), 4'h0, 4'(i));
        s3_done = 1'b1;
      end
    join_none
    repeat (6) @(negedge clk);
    check("s3_in_ready_full", 32'(in_ready), 32'd0);
    check("s3_accepted", 32'(sb_q.size()), 32'd2);
    check("s3_hold_out", 32'(out), 32'h1);
    @(negedge clk);
    check("s3_hold_out2", 32'(out), 32'h1);
    check("s3_hold_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !s3_done; i++) @(posedge clk);
    #1;
    check("s3_sender_done", 32'(s3_done), 32'd1);
    drain();
    check("s3_tx_cnt", 32'(tx_cnt), 32'd6);

    // Scenario 4: counter wrap at CNT_W=3
    clr_pulse();
    for (int i = 0; i < 9; i++)
      send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF);
    drain();
    check("s4_tx_wrap", 32'(tx_cnt), 32'd1);

    // Scenario 5: checker, clr colliding with a handshake, saturation
    clr_pulse();
    send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'b0011, 4'hC);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("s5_tx_cnt", 32'(tx_cnt), 32'd1);
    check("s5_mism_cnt", 32'(mism_cnt), CHK ? 32'd2 : 32'd0);
    check("s5_err", 32'(err), CHK ? 32'd1 : 32'd0);
    send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF);
    @(posedge clk); #1;
    clr = 1'b1;
    check("s5_clr_hs_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    clr = 1'b0;
    check("s5_clr_tx", 32'(tx_cnt), 32'd0);
    check("s5_clr_mism", 32'(mism_cnt), 32'd0);
    check("s5_clr_err", 32'(err), 32'd0);
    send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0);
    send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0);
    drain();
    check("s5_sat_tx", 32'(tx_cnt), 32'd2);
    check("s5_sat_mism", 32'(mism_cnt), CHK ? 32'd7 : 32'd0);
    check("s5_sat_err", 32'(err), CHK ? 32'd1 : 32'd0);

    // Scenario 6: reset with both stages full
    clr_pulse();
    out_ready = 1'b0;
    send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1);
    send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h2, 4'h0, 4'h2);
    check("s6_full_valid", 32'(out_valid), 32'd1);
    check("s6_full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("s6_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    check("s6_out_valid", 32'(out_valid), 32'd0);
    check("s6_tx_cnt", 32'(tx_cnt), 32'd0);
    check("s6_mism_cnt", 32'(mism_cnt), 32'd0);
    check("s6_err", 32'(err), 32'd0);
    out_ready = 1'b1;
    send(4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h4, 4'h0, 4'h4);
    check("s6_lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("s6_lat_valid", 32'(out_valid), 32'd1);
    check("s6_out", 32'(out), 32'h4);
    drain();
    check("s6_tx_after", 32'(tx_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
